// File: rtl/p_int_acc_pkg.sv
// Shared perceptron types: operand precision/signedness descriptor and accumulator FSM states.
// Also provides the DEF_DCONF_INT default descriptor (signed, 8-bit).
`ifndef DEF_DCONF_INT
`define DEF_DCONF_INT p_int_acc_pkg::dconf_t'{sgn: 1'b1, prec: 8'd8}
`endif

package p_int_acc_pkg;

  typedef struct packed {
    logic       sgn;
    logic [7:0] prec;
  } dconf_t;

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } acc_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/p_int_add.sv
// Combinational extend/add/bound step: in1 (accumulator, O_CONF) + in2 (operand, I_CONF).
// Out-of-range sums clamp when P_INT_ACC_SAT_EN is defined, otherwise wrap; ovf flags either case.
`ifndef DEF_DCONF_INT
`define DEF_DCONF_INT p_int_acc_pkg::dconf_t'{sgn: 1'b1, prec: 8'd8}
`endif

module p_int_add
  import p_int_acc_pkg::*;
#(
  parameter dconf_t I_CONF = `DEF_DCONF_INT,
  parameter dconf_t O_CONF = `DEF_DCONF_INT
) (
  input  logic [O_CONF.prec-1:0] in1,
  input  logic [I_CONF.prec-1:0] in2,
  output logic                   ovf,
  output logic [O_CONF.prec-1:0] out
);

  localparam int unsigned P  = int'(O_CONF.prec);
  localparam int unsigned IP = int'(I_CONF.prec);
  // Two guard bits over the wider operand so the raw sum never aliases.
  localparam int unsigned W  = max_u(P, IP) + 2;

  logic signed [W-1:0] a, b, s, lo, hi;

  always_comb begin
    if (O_CONF.sgn) a = {{(W-P){in1[P-1]}}, in1};
    else            a = {{(W-P){1'b0}}, in1};

    if (I_CONF.sgn) b = {{(W-IP){in2[IP-1]}}, in2};
    else            b = {{(W-IP){1'b0}}, in2};

    if (O_CONF.sgn) begin
      lo = {{(W-P+1){1'b1}}, {(P-1){1'b0}}};
      hi = {{(W-P+1){1'b0}}, {(P-1){1'b1}}};
    end else begin
      lo = '0;
      hi = {{(W-P){1'b0}}, {P{1'b1}}};
    end

    s   = a + b;
    ovf = (s < lo) || (s > hi);

`ifdef P_INT_ACC_SAT_EN
    if (s < lo)      out = lo[P-1:0];
    else if (s > hi) out = hi[P-1:0];
    else             out = s[P-1:0];
`else
    out = s[P-1:0];
`endif
  end

endmodule

// File: rtl/p_int_acc.sv
// Handshaked integer accumulator: sums beats until in_last, then presents result/ovf/count.
// Step saturation is selected by P_INT_ACC_SAT_EN (wrap when undefined).
`ifndef DEF_DCONF_INT
`define DEF_DCONF_INT p_int_acc_pkg::dconf_t'{sgn: 1'b1, prec: 8'd8}
`endif

module p_int_acc
  import p_int_acc_pkg::*;
#(
  parameter dconf_t      I_CONF = `DEF_DCONF_INT,
  parameter dconf_t      O_CONF = `DEF_DCONF_INT,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   reset_,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [I_CONF.prec-1:0] in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [O_CONF.prec-1:0] out_data,
  output logic                   out_ovf,
  output logic [CNT_W-1:0]       out_cnt
);

  acc_state_t state, state_nx;

  logic [O_CONF.prec-1:0] acc, sum;
  logic                   ovf, step_ovf;
  logic [CNT_W-1:0]       cnt;

  p_int_add #(
    .I_CONF(I_CONF),
    .O_CONF(O_CONF)
  ) u_add (
    .in1(acc),
    .in2(in_data),
    .ovf(step_ovf),
    .out(sum)
  );

  always_ff @(posedge clk) begin
    if (!reset_) state <= ST_ACC;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_ACC: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_nx = ST_OUT;
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = ST_ACC;
      end
      default: state_nx = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      acc <= '0;
      ovf <= 1'b0;
      cnt <= '0;
    end else if (in_valid && in_ready) begin
      acc <= sum;
      ovf <= ovf | step_ovf;
      if (cnt != '1) cnt <= cnt + CNT_W'(1);
    end else if (out_valid && out_ready) begin
      acc <= '0;
      ovf <= 1'b0;
      cnt <= '0;
    end
  end

  assign out_data = acc;
  assign out_ovf  = ovf;
  assign out_cnt  = cnt;

endmodule

// File: tb/tb_p_int_acc.sv
// Bench for p_int_acc: a signed->signed and a signed->unsigned instance, checked against an
// arithmetic model of per-step bounded accumulation (clamp or wrap per P_INT_ACC_SAT_EN).
module tb_p_int_acc;
  import p_int_acc_pkg::*;

  localparam dconf_t S8 = '{sgn: 1'b1, prec: 8'd8};
  localparam dconf_t U8 = '{sgn: 1'b0, prec: 8'd8};
`ifdef P_INT_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_;
  logic       iv[2], il[2], ordy[2], ir[2], ov[2], oo[2];
  logic [7:0] id[2], od[2], oc[2];

  p_int_acc #(.I_CONF(S8), .O_CONF(S8), .CNT_W(8)) u_s (
    .clk(clk), .reset_(reset_),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]), .in_last(il[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .out_ovf(oo[0]), .out_cnt(oc[0])
  );

  p_int_acc #(.I_CONF(S8), .O_CONF(U8), .CNT_W(8)) u_u (
    .clk(clk), .reset_(reset_),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]), .in_last(il[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_ovf(oo[1]), .out_cnt(oc[1])
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: mathematical accumulator value, sticky overflow, beat count.
  int m_acc[2];
  bit m_ovf[2];
  int m_cnt[2];

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [31:0] dout(input int k);
    if (k == 0) return {{24{od[0][7]}}, od[0]};
    return {24'b0, od[1]};
  endfunction

  // One bounded step of the 8-bit accumulator: true sum, bound test, then clamp or wrap.
  function automatic int mstep(input int acc, input int x, input bit osgn, inout bit ovf);
    int lo, hi, s;
    lo = osgn ? -128 : 0;
    hi = osgn ? 127 : 255;
    s  = acc + x;
    if (s >= lo && s <= hi) return s;
    ovf = 1'b1;
    if (SAT) return (s < lo) ? lo : hi;
    return ((s - lo) & 255) + lo;
  endfunction

  task automatic mclear(input int k);
    m_acc[k] = 0;
    m_ovf[k] = 1'b0;
    m_cnt[k] = 0;
  endtask

  task automatic check_out(input int k, input string tag);
    check({tag, "_valid"}, {31'b0, ov[k]}, 1);
    check({tag, "_data"}, dout(k), m_acc[k]);
    check({tag, "_ovf"}, {31'b0, oo[k]}, {31'b0, m_ovf[k]});
    check({tag, "_cnt"}, {24'b0, oc[k]}, m_cnt[k]);
  endtask

  // Called at a negedge; leaves the bench at the following negedge.
  task automatic beat(input int k, input int d, input bit last);
    iv[k] = 1'b1;
    id[k] = d[7:0];
    il[k] = last;
    check("in_ready", {31'b0, ir[k]}, 1);
    m_acc[k] = mstep(m_acc[k], d, (k == 0), m_ovf[k]);
    if (m_cnt[k] < 255) m_cnt[k]++;
    @(posedge clk); @(negedge clk);
    iv[k] = 1'b0;
    il[k] = 1'b0;
    if (last) check_out(k, "res");
    else begin
      check("mid_valid", {31'b0, ov[k]}, 0);
      check("mid_data", dout(k), m_acc[k]);
    end
  endtask

  // Hold the result for 'hold' cycles with junk beats offered, then take it.
  task automatic drain(input int k, input int hold);
    for (int i = 0; i < hold; i++) begin
      ordy[k] = 1'b0;
      iv[k] = 1'b1;
      id[k] = 8'($urandom);
      il[k] = 1'($urandom);
      @(posedge clk); @(negedge clk);
      check("hold_ready", {31'b0, ir[k]}, 0);
      check_out(k, "hold");
    end
    iv[k] = 1'b0;
    il[k] = 1'b0;
    ordy[k] = 1'b1;
    @(posedge clk); @(negedge clk);
    ordy[k] = 1'b0;
    mclear(k);
    check("take_valid", {31'b0, ov[k]}, 0);
    check("take_ready", {31'b0, ir[k]}, 1);
    check("take_data", dout(k), 0);
    check("take_cnt", {24'b0, oc[k]}, 0);
    check("take_ovf", {31'b0, oo[k]}, 0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; il[k] = 1'b0; ordy[k] = 1'b0; id[k] = '0;
      mclear(k);
    end
    reset_ = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    reset_ = 1'b1;
    check("rst_ready", {31'b0, ir[0]}, 1);
    check("rst_valid", {31'b0, ov[0]}, 0);
    check("rst_data", dout(0), 0);
    check("rst_ovf", {31'b0, oo[0]}, 0);
    check("rst_cnt", {24'b0, oc[0]}, 0);

    // 10 + 20 - 5
    beat(0, 10, 0); beat(0, 20, 0); beat(0, -5, 1);
    check("sum25_data", dout(0), 25);
    check("sum25_cnt", {24'b0, oc[0]}, 3);
    drain(0, 3);

    // 100 + 100: clamps to 127 or wraps to -56
    beat(0, 100, 0); beat(0, 100, 1);
    check("pos_ovf_data", dout(0), SAT ? 127 : -56);
    check("pos_ovf_flag", {31'b0, oo[0]}, 1);
    drain(0, 0);

    // per-step clamp: 100 + 100 - 100 gives 27, not 100
    beat(0, 100, 0); beat(0, 100, 0); beat(0, -100, 1);
    check("step_sat_data", dout(0), SAT ? 27 : 100);
    check("step_sat_ovf", {31'b0, oo[0]}, 1);
    drain(0, 1);

    beat(0, -100, 0); beat(0, -100, 1);
    check("neg_ovf_data", dout(0), SAT ? -128 : 56);
    check("neg_ovf_flag", {31'b0, oo[0]}, 1);
    drain(0, 2);

    // reset mid-sum discards the partial sum
    beat(0, 50, 0);
    reset_ = 1'b0;
    @(posedge clk); @(negedge clk);
    reset_ = 1'b1;
    mclear(0);
    check("midrst_data", dout(0), 0);
    beat(0, 7, 1);
    check("midrst_res_data", dout(0), 7);
    check("midrst_res_cnt", {24'b0, oc[0]}, 1);
    check("midrst_res_ovf", {31'b0, oo[0]}, 0);
    drain(0, 0);

    // signed input into unsigned accumulator going below 0
    beat(1, 5, 0); beat(1, -10, 1);
    check("uns_data", dout(1), SAT ? 0 : 251);
    check("uns_ovf", {31'b0, oo[1]}, 1);
    drain(1, 1);

    // beat counter saturates at all-ones
    for (int i = 0; i < 259; i++) beat(0, 0, 0);
    beat(0, 1, 1);
    check("cnt_sat", {24'b0, oc[0]}, 255);
    drain(0, 0);

    // randomized sums on both instances
    for (int t = 0; t < 30; t++) begin
      int k, n;
      k = int'($urandom_range(0, 1));
      n = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) beat(k, int'($urandom_range(0, 255)) - 128, (i == n - 1));
      drain(k, int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
